// File: rtl/wts_pkg.sv
// Shared constants and types for the wave-table fetch sequencer.
package wts_pkg;

  localparam int WTS_CHANNELS  = 12;
  localparam int WTS_WAVE_LEN  = 32;
  localparam int WTS_RAM_DEPTH = 384;
  localparam int WTS_FREQ_W    = 12;

  typedef logic [3:0]            ch_t;
  typedef logic [4:0]            ptr_t;
  typedef logic [WTS_FREQ_W-1:0] freq_t;
  typedef logic [8:0]            addr_t;

  // CPU access progress: GRANT = cycle G, WAIT = G+1, ACK = G+2.
  typedef enum logic [1:0] {
    CPU_IDLE  = 2'd0,
    CPU_GRANT = 2'd1,
    CPU_WAIT  = 2'd2,
    CPU_ACK   = 2'd3
  } cpu_st_e;

  // A channel's 32 samples sit in one contiguous block of wave memory.
  function automatic addr_t wave_addr(input ch_t ch, input ptr_t ptr);
    return {ch, ptr};
  endfunction

endpackage

// File: rtl/wts_wave_fetch_if.sv
// Bus bundle of the wave fetch block: frequency writes, CPU port, wave RAM
// port and the sample stream to the mixer.
//
// CPU handshake: cpu_req is a level request; cpu_we/cpu_a/cpu_d are held
// stable from request until cpu_ack. cpu_ack is a single-cycle pulse, and
// for reads cpu_q is valid with it and held until the next read ack. The
// master drops cpu_req in the cycle after cpu_ack; a request still high
// then is treated as a fresh access.
interface wts_wave_fetch_if
  import wts_pkg::*;
#(
  parameter int FREQ_W = WTS_FREQ_W
) ();

  logic              freq_we;
  ch_t               freq_ch;
  logic [FREQ_W-1:0] freq_d;
  logic              freq_rst;

  logic              cpu_req;
  logic              cpu_we;
  addr_t             cpu_a;
  logic [7:0]        cpu_d;
  logic              cpu_ack;
  logic [7:0]        cpu_q;

  logic              sram_we;
  addr_t             sram_a;
  logic [7:0]        sram_d;
  logic [7:0]        sram_q;

  logic              wave_valid;
  ch_t               wave_ch;
  logic [7:0]        wave_data;

  cpu_st_e           cpu_state;

  modport slave (
    input  freq_we, freq_ch, freq_d, freq_rst,
    input  cpu_req, cpu_we, cpu_a, cpu_d,
    input  sram_q,
    output cpu_ack, cpu_q,
    output sram_we, sram_a, sram_d,
    output wave_valid, wave_ch, wave_data,
    output cpu_state
  );

  modport master (
    output freq_we, freq_ch, freq_d, freq_rst,
    output cpu_req, cpu_we, cpu_a, cpu_d,
    output sram_q,
    input  cpu_ack, cpu_q,
    input  sram_we, sram_a, sram_d,
    input  wave_valid, wave_ch, wave_data,
    input  cpu_state
  );

endinterface

// File: rtl/wts_ch_state.sv
// Per-channel frequency divisor, step counter and sample pointer.
module wts_ch_state
  import wts_pkg::*;
#(
  parameter int CHANNELS = WTS_CHANNELS,
  parameter int FREQ_W   = WTS_FREQ_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              step_en,
  input  ch_t               step_ch,
  input  logic              wr_en,
  input  ch_t               wr_ch,
  input  logic [FREQ_W-1:0] wr_freq,
  input  logic              wr_rst,
  input  ch_t               rd_ch,
  output ptr_t              rd_ptr
);

  logic [FREQ_W-1:0] freq_r [CHANNELS];
  logic [FREQ_W-1:0] cnt_r  [CHANNELS];
  ptr_t              ptr_r  [CHANNELS];

  assign rd_ptr = (int'(rd_ch) < CHANNELS) ? ptr_r[rd_ch] : '0;

  // Host writes take priority over the stepping update of the same channel.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        freq_r[i] <= '0;
        cnt_r[i]  <= '0;
        ptr_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && wr_ch == ch_t'(i)) begin
          freq_r[i] <= wr_freq;
        end
        if (wr_en && wr_ch == ch_t'(i) && wr_rst) begin
          ptr_r[i] <= '0;
          cnt_r[i] <= '0;
        end else if (step_en && step_ch == ch_t'(i) && freq_r[i] != '0) begin
          // A zero divisor freezes the channel; otherwise count down and
          // advance the pointer each time the counter hits zero.
          if (cnt_r[i] == '0) begin
            cnt_r[i] <= freq_r[i];
            ptr_r[i] <= ptr_r[i] + 5'd1;
          end else begin
            cnt_r[i] <= cnt_r[i] - FREQ_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/wts_wave_fetch.sv
// Time-multiplexed wave-table sequencer: each channel owns a two-cycle slot,
// phase0 fetches its current sample, phase1 is lent to a pending CPU access.
module wts_wave_fetch
  import wts_pkg::*;
#(
  parameter int CHANNELS = WTS_CHANNELS,
  parameter int FREQ_W   = WTS_FREQ_W
) (
  input logic            clk,
  input logic            nreset,
  wts_wave_fetch_if.slave bus
);

  localparam int RAM_DEPTH = CHANNELS * WTS_WAVE_LEN;

  // Slot registers describe the cycle currently presented on sram_*.
  ch_t     slot_ch, slot_ch_nxt;
  logic    slot_ph, slot_ph_nxt;
  cpu_st_e cpu_st, cpu_st_nxt;
  logic    grant;
  logic    cpu_rd_r, cpu_oob_r;
  logic    fetch_v;
  ch_t     fetch_ch;
  ptr_t    rd_ptr;

  logic       sram_we_nxt, sram_we_r;
  addr_t      sram_a_nxt, sram_a_r;
  logic [7:0] sram_d_nxt, sram_d_r;
  logic [7:0] cpu_q_r;
  logic       wave_valid_r;
  ch_t        wave_ch_r;
  logic [7:0] wave_data_r;

  wts_ch_state #(
    .CHANNELS (CHANNELS),
    .FREQ_W   (FREQ_W)
  ) u_ch_state (
    .clk     (clk),
    .nreset  (nreset),
    .step_en (slot_ph),
    .step_ch (slot_ch),
    .wr_en   (bus.freq_we && (int'(bus.freq_ch) < CHANNELS)),
    .wr_ch   (bus.freq_ch),
    .wr_freq (bus.freq_d),
    .wr_rst  (bus.freq_rst),
    .rd_ch   (slot_ch_nxt),
    .rd_ptr  (rd_ptr)
  );

  // Next slot: phase toggles every cycle, channel advances after phase1.
  always_comb begin
    slot_ph_nxt = ~slot_ph;
    slot_ch_nxt = slot_ch;
    if (slot_ph) begin
      slot_ch_nxt = (slot_ch == ch_t'(CHANNELS - 1)) ? '0 : slot_ch + 4'd1;
    end
  end

  // Next SRAM command: sample fetch in phase0, CPU access or idle in phase1.
  always_comb begin
    grant       = 1'b0;
    sram_we_nxt = 1'b0;
    sram_a_nxt  = '0;
    sram_d_nxt  = '0;
    if (!slot_ph_nxt) begin
      sram_a_nxt = wave_addr(slot_ch_nxt, rd_ptr);
    end else if (bus.cpu_req && cpu_st == CPU_IDLE) begin
      grant       = 1'b1;
      sram_a_nxt  = bus.cpu_a;
      sram_d_nxt  = bus.cpu_d;
      // Addresses beyond the wave RAM must never be written.
      sram_we_nxt = bus.cpu_we && (int'(bus.cpu_a) < RAM_DEPTH);
    end
  end

  // CPU access progress: one grant outstanding, retired two cycles later.
  always_comb begin
    cpu_st_nxt = cpu_st;
    case (cpu_st)
      CPU_IDLE:  if (grant) cpu_st_nxt = CPU_GRANT;
      CPU_GRANT: cpu_st_nxt = CPU_WAIT;
      CPU_WAIT:  cpu_st_nxt = CPU_ACK;
      CPU_ACK:   cpu_st_nxt = CPU_IDLE;
      default:   cpu_st_nxt = CPU_IDLE;
    endcase
  end

  // Slot sequencer state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot_ch <= '0;
      slot_ph <= 1'b0;
    end else begin
      slot_ch <= slot_ch_nxt;
      slot_ph <= slot_ph_nxt;
    end
  end

  // Registered SRAM command port.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sram_we_r <= 1'b0;
      sram_a_r  <= '0;
      sram_d_r  <= '0;
    end else begin
      sram_we_r <= sram_we_nxt;
      sram_a_r  <= sram_a_nxt;
      sram_d_r  <= sram_d_nxt;
    end
  end

  // CPU FSM state plus the attributes of the granted access.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cpu_st    <= CPU_IDLE;
      cpu_rd_r  <= 1'b0;
      cpu_oob_r <= 1'b0;
    end else begin
      cpu_st <= cpu_st_nxt;
      if (grant) begin
        cpu_rd_r  <= ~bus.cpu_we;
        cpu_oob_r <= int'(bus.cpu_a) >= RAM_DEPTH;
      end
    end
  end

  // Read data lands on sram_q in G+1 and is held for the master.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cpu_q_r <= '0;
    end else if (cpu_st == CPU_WAIT && cpu_rd_r) begin
      cpu_q_r <= cpu_oob_r ? 8'h00 : bus.sram_q;
    end
  end

  // Sample pipeline: address in n, data on sram_q in n+1, strobe in n+2.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fetch_v      <= 1'b0;
      fetch_ch     <= '0;
      wave_valid_r <= 1'b0;
      wave_ch_r    <= '0;
      wave_data_r  <= '0;
    end else begin
      fetch_v      <= ~slot_ph;
      fetch_ch     <= slot_ch;
      wave_valid_r <= fetch_v;
      if (fetch_v) begin
        wave_ch_r   <= fetch_ch;
        wave_data_r <= bus.sram_q;
      end
    end
  end

  assign bus.sram_we    = sram_we_r;
  assign bus.sram_a     = sram_a_r;
  assign bus.sram_d     = sram_d_r;
  assign bus.cpu_ack    = (cpu_st == CPU_ACK);
  assign bus.cpu_q      = cpu_q_r;
  assign bus.wave_valid = wave_valid_r;
  assign bus.wave_ch    = wave_ch_r;
  assign bus.wave_data  = wave_data_r;
  assign bus.cpu_state  = cpu_st;

endmodule

// File: doc/wts_wave_fetch.md
Name: wts_wave_fetch

Overview:
- Time-multiplexed wave-table sequencer that sits directly upstream of wts_ram (384x8 single-port, 1-cycle read latency) and is the only block driving its sram_we/sram_a/sram_d.
- Steps 12 channels x 32-sample waveforms, fetches each channel's current sample, and streams samples to the mixer.
- Interleaves CPU read/write accesses to wave memory in reserved cycles.

Parameters:
- CHANNELS, 12, number of channels; CHANNELS*32 <= 512.
- FREQ_W, 12, width of the per-channel frequency divisor.

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- freq_we  in  1  frequency register write strobe
- freq_ch  in  4  target channel of freq write
- freq_d  in  FREQ_W  divisor value
- freq_rst  in  1  with freq_we: also clear channel pointer and counter
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  1 = write, 0 = read
- cpu_a  in  9  wave memory address
- cpu_d  in  8  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_q  out  8  read data, valid with cpu_ack, held until next read ack
- sram_we  out  1  to wts_ram
- sram_a  out  9  to wts_ram
- sram_d  out  8  to wts_ram
- sram_q  in  8  from wts_ram, valid the cycle after its address
- wave_valid  out  1  sample strobe
- wave_ch  out  4  channel of the sample
- wave_data  out  8  signed sample

Behaviour:
- Reset: all outputs 0. Slot = ch0/phase0. All freq/cnt/ptr = 0. Any outstanding CPU access is aborted with no ack.
- Slot sequence: ch 0..CHANNELS-1, 2 cycles each (phase0, phase1), full round = 24 clocks, wraps to ch0.
- Output timing: sram_* are registered outputs; the values below hold during the named cycle.
- Phase0 of ch k (cycle n): sram_a={k[3:0],ptr[k]}, sram_we=0.
  - sram_q is valid in n+1 and is captured at the end of n+1.
  - wave_valid=1, wave_ch=k, wave_data=sample during n+2 (1-cycle pulse).
- Phase1 (cycle G): if cpu_req=1 and no access outstanding, grant.
  - sram_a=cpu_a, sram_d=cpu_d, sram_we=cpu_we.
  - Exception: sram_we is forced 0 when cpu_a>=384.
  - Otherwise sram_we=0 in phase1.
- CPU completion: cpu_ack pulses in G+2.
  - Read: cpu_q=sram_q captured at the end of G+1, or 8'h00 if cpu_a>=384.
  - Outstanding clears at the end of G+2, so the next possible grant is G+4.
  - Master holds cpu_we/a/d stable from request to ack and deasserts cpu_req in the cycle after ack; req still high then is a new request.
- Channel stepping, evaluated at the end of phase1 of slot k:
  - freq[k]==0: cnt and ptr hold (channel frozen).
  - cnt[k]==0: cnt<=freq[k], ptr<=ptr+1 mod 32.
  - Else: cnt<=cnt-1.
  - Resulting step period = (freq+1)*24 clocks.
- Frequency writes:
  - freq_we is accepted in any cycle; freq_ch>=CHANNELS is ignored.
  - freq_rst=1 also sets ptr=0, cnt=0.
  - Collision with the same channel's stepping update: the write wins for freq and, if freq_rst=1, for ptr/cnt.
- Widths: ptr 5 bits wrap 31->0; cnt FREQ_W bits, never underflows.

Decomposition:
- Package wts_pkg:
  - WTS_CHANNELS=12, WTS_WAVE_LEN=32, WTS_RAM_DEPTH=384, WTS_FREQ_W=12.
  - Typedefs ch_t (4b), ptr_t (5b), freq_t.
- One sub-module, wts_ch_state: per-channel freq/cnt/ptr register file with step and write/rst logic.
- Slot sequencer and CPU arbitration stay in the top.

Test Plan:
1. Reset release with no traffic -> all outputs 0 in reset; wave_valid pulses every 2 clocks; wave_ch cycles 0..11; first pulse 2 cycles after the first phase0.
2. CPU writes addr i, data (i+100)&0xFF, i=0..383, then reads all -> each ack at G+2, cpu_q matches. Write to 0x180 -> sram_we stays 0; read of 0x180 returns 0x00.
3. freq[3]=0 -> ch3 address stays 96 forever. freq[3]=1 -> ptr advances every 48 clocks and wraps from address 127 to 96 after 32 steps.
4. Preload ch5 samples = index 0..31, freq[5]=9 -> ch5 wave_data increments by 1 every 240 clocks, 31->0 wrap.
5. freq_we with freq_rst=1 to ch7 in ch7's phase1 while cnt==0 -> ptr=0, cnt=0, new freq loaded; stepping update discarded.
6. nreset asserted in G+1 of a pending CPU read -> no cpu_ack, outputs 0; re-issued read after release acks with correct data.
